// File: rtl/pipe_mux_buf.sv
// N-way operand selector feeding a registered 2-entry skid buffer with valid/ready handshakes.
// Define MUX_SEL_CHECK_EN to flag out-of-range selects (zeroed data, out_err, saturating err_count).
module pipe_mux_buf #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic [7:0]              err_count
);

  logic [WIDTH-1:0] r_data [2];
  logic [SEL_W-1:0] r_sel  [2];
  logic             r_rdPtr;
  logic             r_wrPtr;
  logic [1:0]       r_count;

  logic             w_accept;
  logic             w_pop;
  logic [WIDTH-1:0] w_selData;

  // Handshake flags come from the registered count only, so out_ready never reaches in_ready.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // An unmatched select falls through to the default word.
  always_comb begin
`ifdef MUX_SEL_CHECK_EN
    w_selData = '0;
`else
    w_selData = in_data[WIDTH-1:0];
`endif
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_selData = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= 2'd0;
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_sel[i]  <= '0;
      end
    end else if (flush) begin
      r_count <= 2'd0;
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data[r_wrPtr] <= w_selData;
        r_sel[r_wrPtr]  <= sel;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data = r_data[r_rdPtr];
  assign out_sel  = r_sel[r_rdPtr];

`ifdef MUX_SEL_CHECK_EN
  logic       r_err [2];
  logic [7:0] r_errCount;
  logic       w_selErr;

  assign w_selErr = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err[0]   <= 1'b0;
      r_err[1]   <= 1'b0;
      r_errCount <= 8'd0;
    end else if (!flush && w_accept) begin
      r_err[r_wrPtr] <= w_selErr;
      if (w_selErr && (r_errCount != 8'hFF)) begin
        r_errCount <= r_errCount + 8'd1;
      end
    end
  end

  assign out_err   = r_err[r_rdPtr];
  assign err_count = r_errCount;
`else
  assign out_err   = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_pipe_mux_buf.sv
// Self-checking bench for pipe_mux_buf: directed scenarios then randomized traffic against a queue model.
module tb_pipe_mux_buf;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 5;
  localparam int SEL_W  = 3;

  logic                    clock;
  logic                    reset;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic [7:0]              err_count;

  pipe_mux_buf #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_err(out_err), .err_count(err_count)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
    logic             e;
  } entry_t;

  entry_t           q[$];
  int               modelErrCount;
  logic [WIDTH-1:0] inWords [NUM_IN];
  int               checks;
  int               errors;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t expectEntry(input logic [SEL_W-1:0] s);
    entry_t en;
    en.s = s;
    en.e = 1'b0;
    if (int'(s) < NUM_IN) begin
      en.d = inWords[int'(s)];
    end else begin
`ifdef MUX_SEL_CHECK_EN
      en.d = '0;
      en.e = 1'b1;
`else
      en.d = inWords[0];
`endif
    end
    return en;
  endfunction

  task automatic applyStimulus(input logic iv, input logic [SEL_W-1:0] s, input logic ordy,
                               input logic fl, input logic rst);
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = inWords[k];
  endtask

  // Model: a bounded queue of at most two entries with reset/flush priority.
  task automatic modelUpdate(input logic iv, input logic [SEL_W-1:0] s, input logic ordy,
                             input logic fl, input logic rst);
    bit acc;
    bit pop;
    entry_t en;
    acc = iv && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    en  = expectEntry(s);
    if (rst) begin
      q.delete();
      modelErrCount = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(en);
        if (en.e && modelErrCount < 255) modelErrCount++;
      end
    end
  endtask

  task automatic checkOutput();
    compare("in_ready", 64'(in_ready), 64'(q.size() != 2));
    compare("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() > 0) begin
      compare("out_data", 64'(out_data), 64'(q[0].d));
      compare("out_sel", 64'(out_sel), 64'(q[0].s));
      compare("out_err", 64'(out_err), 64'(q[0].e));
    end
    compare("err_count", 64'(err_count), 64'(modelErrCount));
  endtask

  task automatic step(input logic iv, input logic [SEL_W-1:0] s, input logic ordy,
                      input logic fl, input logic rst);
    applyStimulus(iv, s, ordy, fl, rst);
    modelUpdate(iv, s, ordy, fl, rst);
    @(posedge clock);
    @(negedge clock);
    checkOutput();
  endtask

  task automatic checkResetValues(input string tag);
    compare({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    compare({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    compare({tag, "_out_data"}, 64'(out_data), 64'd0);
    compare({tag, "_out_sel"}, 64'(out_sel), 64'd0);
    compare({tag, "_out_err"}, 64'(out_err), 64'd0);
    compare({tag, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelErrCount = 0;
    for (int k = 0; k < NUM_IN; k++) inWords[k] = 32'h1000 + k;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);

    // Reset values
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkResetValues("rst");

    // Single accept with sel=3, then drain
    step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    compare("tp1_data", 64'(out_data), 64'h1003);
    compare("tp1_sel", 64'(out_sel), 64'd3);
    step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Fill with out_ready low, then drain in order
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    compare("fill_in_ready", 64'(in_ready), 64'd0);
    compare("fill_head", 64'(out_data), 64'h1001);
    step(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    compare("drain_second", 64'(out_data), 64'h1004);
    step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    compare("drain_empty", 64'(out_valid), 64'd0);

    // Count 1: accept and pop together
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    compare("accpop_data", 64'(out_data), 64'h1002);
    compare("accpop_in_ready", 64'(in_ready), 64'd1);

    // Count 2 then flush with a concurrent accept
    step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
    compare("flush_out_valid", 64'(out_valid), 64'd0);
    compare("flush_in_ready", 64'(in_ready), 64'd1);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    compare("flush_stays_empty", 64'(out_valid), 64'd0);

    // Out-of-range select three times
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
`ifdef MUX_SEL_CHECK_EN
      compare("oor_data", 64'(out_data), 64'h0);
      compare("oor_err", 64'(out_err), 64'd1);
`else
      compare("oor_data", 64'(out_data), 64'h1000);
      compare("oor_err", 64'(out_err), 64'd0);
`endif
    end
`ifdef MUX_SEL_CHECK_EN
    compare("oor_count", 64'(err_count), 64'd3);
`else
    compare("oor_count", 64'(err_count), 64'd0);
`endif

    // Reset dominates flush mid-stream at count 2
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd4, 1'b1, 1'b1, 1'b1);
    checkResetValues("midrst");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic iv;
      logic ordy;
      logic fl;
      logic rst;
      logic [SEL_W-1:0] s;
      for (int k = 0; k < NUM_IN; k++) inWords[k] = $urandom;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 29) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      s    = SEL_W'($urandom_range(0, 7));
      step(iv, s, ordy, fl, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
